// File: rtl/grace_shift_unit.sv
// grace_shift_unit
// Multi-cycle handshaked shift/rotate unit. A request (dIN, Op, ShAmount) is
// taken over InValid/InReady. The operand is then shifted by at most StepMax
// positions per cycle, and the result is held on dOUT with OutValid until
// OutReady takes it.
//
// Ports:
//   Clk, Rst_n           clock, asynchronous active-low reset
//   InValid / InReady    request handshake
//   Op                   000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, else pass
//   dIN, ShAmount        operand and shift count
//   OutValid / OutReady  result handshake
//   dOUT                 result (zero unless OutValid)
//   Busy                 high in SHIFT or DONE
//   CarryOut, Zero       result flags, present only with GRACE_SHIFT_FLAGS_EN
//
// Build option: define GRACE_SHIFT_FLAGS_EN to add the CarryOut/Zero ports
// and the carry register. The data path and the timing do not change.
//
// state | meaning
// IDLE  | waiting for a request, InReady=1
// SHIFT | applying up to StepMax positions per cycle
// DONE  | result held on dOUT until OutReady
module grace_shift_unit #(
  parameter int BitWidth = 32,
  parameter int StepMax  = 4,
  localparam int ShiftWidth = $clog2(BitWidth)
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [2:0]            Op,
  input  logic [BitWidth-1:0]   dIN,
  input  logic [ShiftWidth-1:0] ShAmount,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [BitWidth-1:0]   dOUT,
`ifdef GRACE_SHIFT_FLAGS_EN
  output logic                  CarryOut,
  output logic                  Zero,
`endif
  output logic                  Busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  // The step limit needs one extra bit because StepMax may equal BitWidth.
  localparam logic [ShiftWidth:0] StepMaxW = (ShiftWidth + 1)'(StepMax);

  state_t                state_q, state_d;
  logic [BitWidth-1:0]   data_q, data_d;
  logic [2:0]            op_q, op_d;
  logic [ShiftWidth-1:0] rem_q, rem_d;
  logic                  sign_q, sign_d;

  logic [ShiftWidth-1:0] step;
  logic [ShiftWidth-1:0] step_inv;
  logic [BitWidth-1:0]   step_data;

  // In SHIFT the step is always 1..BitWidth-1, so BitWidth-step fits in
  // ShiftWidth bits and equals the two's complement negation of step.
  always_comb begin
    if ({1'b0, rem_q} < StepMaxW) step = rem_q;
    else                          step = StepMaxW[ShiftWidth-1:0];
    step_inv = '0 - step;
  end

  always_comb begin
    unique case (op_q)
      OP_SLL:  step_data = data_q << step;
      OP_SRL:  step_data = data_q >> step;
      // Fill from the sign captured at acceptance, not the current MSB.
      OP_SRA:  step_data = (data_q >> step) | ({BitWidth{sign_q}} << step_inv);
      OP_ROL:  step_data = (data_q << step) | (data_q >> step_inv);
      OP_ROR:  step_data = (data_q >> step) | (data_q << step_inv);
      default: step_data = data_q;
    endcase
  end

  // Next-state and data-path registers.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    unique case (state_q)
      ST_IDLE: begin
        if (InValid) begin
          data_d = dIN;
          op_d   = Op;
          rem_d  = ShAmount;
          sign_d = dIN[BitWidth-1];
          if (ShAmount == '0 || Op > OP_ROR) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_data;
        rem_d  = rem_q - step;
        if (rem_q == step) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (OutReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
    end
  end

`ifdef GRACE_SHIFT_FLAGS_EN
  logic                  carry_q, carry_d;
  logic [ShiftWidth-1:0] idx_r;

  // Last bit to leave (or wrap) in this step: data[W-step] for leftward
  // ops, data[step-1] for rightward ops.
  always_comb begin
    idx_r   = step - 1'b1;
    carry_d = carry_q;
    if (state_q == ST_IDLE && InValid) begin
      carry_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      unique case (op_q)
        OP_SLL, OP_ROL:         carry_d = data_q[step_inv];
        OP_SRL, OP_SRA, OP_ROR: carry_d = data_q[idx_r];
        default:                carry_d = carry_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

  always_comb begin
    CarryOut = (state_q == ST_DONE) && carry_q;
    Zero     = (state_q == ST_DONE) && (data_q == '0);
  end
`endif

  // Outputs depend on registered state only.
  always_comb begin
    InReady  = (state_q == ST_IDLE);
    OutValid = (state_q == ST_DONE);
    Busy     = (state_q != ST_IDLE);
    dOUT     = (state_q == ST_DONE) ? data_q : '0;
  end

endmodule

// File: tb/tb_grace_shift_unit.sv
module tb_grace_shift_unit;
  localparam int BW = 8;
  localparam int SM = 4;
  localparam int SW = 3;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          InValid = 1'b0;
  logic          OutReady = 1'b0;
  logic [2:0]    Op = '0;
  logic [BW-1:0] dIN = '0;
  logic [SW-1:0] ShAmount = '0;
  logic          InReady, OutValid, Busy;
  logic [BW-1:0] dOUT;
`ifdef GRACE_SHIFT_FLAGS_EN
  logic          CarryOut, Zero;
`endif

  grace_shift_unit #(.BitWidth(BW), .StepMax(SM)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .InValid(InValid), .InReady(InReady),
    .Op(Op), .dIN(dIN), .ShAmount(ShAmount),
    .OutValid(OutValid), .OutReady(OutReady), .dOUT(dOUT),
`ifdef GRACE_SHIFT_FLAGS_EN
    .CarryOut(CarryOut), .Zero(Zero),
`endif
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [BW-1:0] d;
    logic          c;
    int            lat;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: one bit at a time, n times.
  function automatic exp_t model(input logic [2:0] op, input logic [BW-1:0] din, input int n);
    exp_t          e;
    logic [BW-1:0] d;
    logic          c;
    logic          s;
    d = din;
    c = 1'b0;
    s = din[BW-1];
    if (op > 3'd4 || n == 0) begin
      e.d = din; e.c = 1'b0; e.lat = 0;
      return e;
    end
    for (int i = 0; i < n; i++) begin
      case (op)
        3'd0: begin c = d[BW-1]; d = {d[BW-2:0], 1'b0}; end
        3'd1: begin c = d[0];    d = {1'b0, d[BW-1:1]}; end
        3'd2: begin c = d[0];    d = {s, d[BW-1:1]}; end
        3'd3: begin c = d[BW-1]; d = {d[BW-2:0], d[BW-1]}; end
        default: begin c = d[0]; d = {d[0], d[BW-1:1]}; end
      endcase
    end
    e.d = d; e.c = c; e.lat = (n + SM - 1) / SM;
    return e;
  endfunction

  // Drive at #1 after a rising edge; the request is taken at the next edge
  // where InReady is high.
  task automatic send(input logic [2:0] op, input logic [BW-1:0] din, input logic [SW-1:0] amt);
    int w;
    w = 0;
    InValid  = 1'b1;
    Op       = op;
    dIN      = din;
    ShAmount = amt;
    while (!InReady && w < 50) begin
      @(posedge Clk); #1;
      w++;
    end
    if (w >= 50) chk("accept_timeout", 32'(InReady), 32'd1);
    @(posedge Clk);
    sbq.push_back(model(op, din, int'(amt)));
    #1;
    InValid = 1'b0;
  endtask

  task automatic collect(input bit chk_lat);
    int   k;
    exp_t e;
    k = 0;
    while (!OutValid && k < 50) begin
      chk("busy_wait", 32'(Busy), 32'd1);
      @(posedge Clk); #1;
      k++;
    end
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      if (chk_lat) chk("latency", 32'(k), 32'(e.lat));
      chk("out_valid", 32'(OutValid), 32'd1);
      chk("dout", 32'(dOUT), 32'(e.d));
      chk("in_ready_done", 32'(InReady), 32'd0);
`ifdef GRACE_SHIFT_FLAGS_EN
      chk("carry", 32'(CarryOut), 32'(e.c));
      chk("zero", 32'(Zero), 32'(e.d == '0));
`endif
    end
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    chk("handoff_valid", 32'(OutValid), 32'd0);
    chk("handoff_ready", 32'(InReady), 32'd1);
    chk("handoff_busy", 32'(Busy), 32'd0);
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [BW-1:0] din;
    logic [SW-1:0] amt;
  } req_t;

  req_t dir_tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_in_ready", 32'(InReady), 32'd1);
    chk("rst_out_valid", 32'(OutValid), 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("rel_in_ready", 32'(InReady), 32'd1);
    chk("rel_out_valid", 32'(OutValid), 32'd0);
    chk("rel_busy", 32'(Busy), 32'd0);
    chk("rel_dout", 32'(dOUT), 32'd0);
`ifdef GRACE_SHIFT_FLAGS_EN
    chk("rel_carry", 32'(CarryOut), 32'd0);
    chk("rel_zero", 32'(Zero), 32'd0);
`endif

    dir_tbl.push_back('{3'd0, 8'h16, 3'd2});
    dir_tbl.push_back('{3'd2, 8'h96, 3'd3});
    dir_tbl.push_back('{3'd1, 8'h96, 3'd3});
    dir_tbl.push_back('{3'd4, 8'h16, 3'd7});
    dir_tbl.push_back('{3'd3, 8'h81, 3'd1});
    dir_tbl.push_back('{3'd1, 8'h80, 3'd0});
    dir_tbl.push_back('{3'd7, 8'hA5, 3'd5});
    dir_tbl.push_back('{3'd0, 8'h80, 3'd1});
    dir_tbl.push_back('{3'd2, 8'h7F, 3'd7});
    foreach (dir_tbl[i]) begin
      send(dir_tbl[i].op, dir_tbl[i].din, dir_tbl[i].amt);
      collect(1'b1);
    end

    for (int i = 0; i < 24; i++) begin
      r.op  = 3'($urandom_range(0, 7));
      r.din = 8'($urandom);
      r.amt = 3'($urandom_range(0, 7));
      send(r.op, r.din, r.amt);
      collect(1'b1);
    end

    // Backpressure with a competing request held on the input.
    send(3'd0, 8'h16, 3'd2);
    begin
      int k;
      k = 0;
      while (!OutValid && k < 50) begin
        @(posedge Clk); #1;
        k++;
      end
    end
    InValid  = 1'b1;
    Op       = 3'd1;
    dIN      = 8'h33;
    ShAmount = 3'd1;
    repeat (5) begin
      @(posedge Clk); #1;
      chk("bp_dout", 32'(dOUT), 32'h58);
      chk("bp_in_ready", 32'(InReady), 32'd0);
      chk("bp_out_valid", 32'(OutValid), 32'd1);
    end
    collect(1'b0);
    send(3'd1, 8'h33, 3'd1);
    collect(1'b1);

    // Reset in the middle of a SHIFT.
    send(3'd0, 8'hFF, 3'd7);
    chk("mid_busy", 32'(Busy), 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(OutValid), 32'd0);
    chk("mid_rst_dout", 32'(dOUT), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    sbq.delete();
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("post_rst_ready", 32'(InReady), 32'd1);
    send(3'd0, 8'hFF, 3'd7);
    collect(1'b1);
    send(3'd4, 8'h01, 3'd5);
    collect(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grace_shift_unit.md
# grace_shift_unit

Multi-cycle, handshaked shift/rotate unit; sequential successor to the single-cycle combinational shifter. Accepts an operand, operation and shift amount over a valid/ready interface, shifts by at most StepMax bit positions per cycle, then holds the result until it is consumed. Adds arithmetic right shift and rotate-right, and optional carry/zero flags. Sits between the ALU issue stage and writeback for area-constrained configurations.

## Interface
- BitWidth, 32: data width; power of two, ≥ 4.
- StepMax, 4: maximum shift positions per cycle; power of two, 1..BitWidth.
- ShiftWidth (localparam): $clog2(BitWidth).
- Clk  in  1  clock; all state changes on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- InValid  in  1  request valid.
- InReady  out  1  unit can accept a request.
- Op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 pass-through.
- dIN  in  BitWidth  operand.
- ShAmount  in  ShiftWidth  shift count, 0..BitWidth-1.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts result.
- dOUT  out  BitWidth  result.
- Busy  out  1  high in SHIFT or DONE.
- CarryOut  out  1  flag (GRACE_SHIFT_FLAGS_EN only).
- Zero  out  1  flag (GRACE_SHIFT_FLAGS_EN only).

## Operation
- States: IDLE, SHIFT, DONE. Registers: data, op, remaining count, carry.
- IDLE: InReady=1. On InValid: capture dIN, Op, ShAmount into remaining; carry cleared.
  - remaining=0 or Op pass-through → DONE.
  - Otherwise → SHIFT.
- SHIFT: each edge applies step = min(remaining, StepMax) to data; remaining -= step; → DONE when remaining reaches 0.
- DONE: OutValid=1, dOUT = data register. On OutReady → IDLE.
- InReady=0 in SHIFT and DONE; InValid ignored there. No request is dropped or overwritten.
- Op semantics per step s:
  - SLL: zero-fill LSBs.
  - SRL: zero-fill MSBs.
  - SRA: replicate the sign bit captured at acceptance.
  - ROL/ROR: bits leaving one end re-enter at the other.
- Result equals the single-shot shift by ShAmount, independent of StepMax.
- Reset values: state IDLE, InReady=1 after reset release, OutValid=0, Busy=0, dOUT=0, CarryOut=0, Zero=0.
- Reset asserted mid-operation: immediate return to IDLE and all outputs at reset values. The in-flight result is discarded.

## Timing
- Acceptance edge E0 (InValid && InReady).
- N = ShAmount, L = ceil(N/StepMax); L=0 when N=0 or Op is pass-through.
- OutValid rises after edge E0+L, i.e. the result is available L+1 cycles after the request is presented.
- dOUT and flags are stable while OutValid=1 and OutReady=0, for unbounded backpressure.
- Result handoff edge Ed (OutValid && OutReady) returns the unit to IDLE. The next request can be accepted at Ed+1 at the earliest, so back-to-back throughput is one op per L+2 cycles.
- No combinational path from InValid to InReady or from OutReady to OutValid.

## Configuration
- GRACE_SHIFT_FLAGS_EN defined: CarryOut and Zero ports and logic present.
  - CarryOut: last bit shifted out for SLL/SRL/SRA; last bit wrapped for ROL/ROR; 0 when N=0 or pass-through.
  - Zero: 1 when dOUT==0.
  - Both are valid only with OutValid.
- Undefined: both ports and their registers are absent. Data path and timing are identical.

## Test plan
- BitWidth=8, StepMax=4, SLL dIN=0x16, ShAmount=2 → dOUT=0x58, L=1, CarryOut=0, Zero=0.
- SRA dIN=0x96, ShAmount=3 → dOUT=0xF2, L=1, CarryOut=1. SRL same inputs → 0x12.
- ROR dIN=0x16, ShAmount=7 → dOUT=0x2C, L=2, CarryOut=0. ROL dIN=0x81, ShAmount=1 → 0x03, CarryOut=1.
- SRL dIN=0x80, ShAmount=0 → dOUT=0x80, OutValid the cycle after acceptance, CarryOut=0. Op=111 with ShAmount=5 → dOUT=dIN, L=0.
- Backpressure: hold OutReady=0 for 5 cycles while driving InValid=1 with new data → dOUT unchanged, InReady=0, second request accepted only after the result handoff.
- Assert Rst_n=0 during SHIFT of SLL 0xFF by 7 → OutValid=0, dOUT=0, Busy=0 immediately. After release, InReady=1 and the next op completes correctly.
